frame_pass_sequencer: RTL

Parametrised frame-processing sequencer for the camera pipeline on the 25 MHz VGA clock. It waits for a captured frame, then runs NUM_PASSES image-processing passes in order, each with a reset/enable/done handshake. Results go to ping-pong result banks so the display never shows a half-written image. It supports live, continuous and single-shot modes, a per-pass watchdog, and a completed-sequence counter.

---
 rtl/frame_pass_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/frame_pass_sequencer.sv
// rtl/frame_pass_sequencer.sv - frame-triggered multi-pass sequencer with ping-pong result banks
module frame_pass_sequencer #(
  parameter int NUM_PASSES = 2,
  parameter int TIMEOUT_W  = 20,
  parameter int FCNT_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            mode_i,
  input  logic                  trigger_i,
  input  logic                  frame_done_i,
  input  logic                  vsync_i,
  input  logic [NUM_PASSES-1:0] pass_done_i,
  output logic [NUM_PASSES-1:0] pass_rst_o,
  output logic [NUM_PASSES-1:0] pass_en_o,
  output logic [2:0]            active_pass_o,
  output logic                  wr_bank_o,
  output logic [1:0]            disp_sel_o,
  output logic                  busy_o,
  output logic                  seq_done_o,
  output logic                  timeout_o,
  output logic [FCNT_W-1:0]     frame_cnt_o
);

  typedef enum logic [2:0] {
    IDLE_LIVE, WAIT_FRAME, PASS_RST, PASS_RUN, PASS_CLR, SWAP, HOLD
  } state_t;

  state_t                state, state_nx;
  logic [2:0]            k, k_nx;
  logic                  wr_bank, wr_bank_nx;
  logic                  result_valid, result_valid_nx;
  logic                  abort, abort_nx;
  logic                  timeout, timeout_nx;
  logic [TIMEOUT_W-1:0]  watchdog, watchdog_nx;
  logic [FCNT_W-1:0]     frame_cnt, frame_cnt_nx;
  logic [NUM_PASSES-1:0] k_sel;
  logic                  mode_cont, mode_single, mode_live;

  assign mode_cont   = (mode_i == 2'b01);
  assign mode_single = (mode_i == 2'b10);
  assign mode_live   = (mode_i == 2'b00) || (mode_i == 2'b11);
  assign k_sel       = NUM_PASSES'(1) << k;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE_LIVE;
      k            <= 3'd0;
      wr_bank      <= 1'b0;
      result_valid <= 1'b0;
      abort        <= 1'b0;
      timeout      <= 1'b0;
      watchdog     <= '0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nx;
      k            <= k_nx;
      wr_bank      <= wr_bank_nx;
      result_valid <= result_valid_nx;
      abort        <= abort_nx;
      timeout      <= timeout_nx;
      watchdog     <= watchdog_nx;
      frame_cnt    <= frame_cnt_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    k_nx            = k;
    wr_bank_nx      = wr_bank;
    result_valid_nx = result_valid;
    abort_nx        = abort;
    timeout_nx      = timeout;
    watchdog_nx     = watchdog;
    frame_cnt_nx    = frame_cnt;
    case (state)
      IDLE_LIVE: begin
        timeout_nx = 1'b0;
        if (mode_cont || (mode_single && trigger_i)) state_nx = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_done_i) begin
          state_nx = PASS_RST;
          k_nx     = 3'd0;
        end else if (mode_live) begin
          state_nx = IDLE_LIVE;
        end
      end
      PASS_RST: begin
        watchdog_nx = '0;
        state_nx    = PASS_RUN;
      end
      PASS_RUN: begin
        watchdog_nx = watchdog + TIMEOUT_W'(1);
        // done is checked first so it wins a tie with the watchdog
        if (|(pass_done_i & k_sel)) begin
          state_nx = PASS_CLR;
        end else if (&watchdog) begin
          abort_nx   = 1'b1;
          timeout_nx = 1'b1;
          state_nx   = PASS_CLR;
        end
      end
      PASS_CLR: begin
        if (abort) begin
          abort_nx = 1'b0;
          k_nx     = 3'd0;
          state_nx = mode_cont ? WAIT_FRAME : IDLE_LIVE;
        end else if (k < 3'(NUM_PASSES - 1)) begin
          k_nx     = k + 3'd1;
          state_nx = PASS_RST;
        end else begin
          state_nx = SWAP;
        end
      end
      SWAP: begin
        wr_bank_nx      = ~wr_bank;
        result_valid_nx = 1'b1;
        frame_cnt_nx    = frame_cnt + FCNT_W'(1);
        k_nx            = 3'd0;
        if (mode_cont)        state_nx = WAIT_FRAME;
        else if (mode_single) state_nx = HOLD;
        else                  state_nx = IDLE_LIVE;
      end
      HOLD: begin
        if (trigger_i || mode_cont) state_nx = WAIT_FRAME;
        else if (mode_live)         state_nx = IDLE_LIVE;
      end
      default: state_nx = IDLE_LIVE;
    endcase
  end

  always_comb begin
    pass_rst_o = '0;
    pass_en_o  = '0;
    seq_done_o = 1'b0;
    disp_sel_o = 2'b00;
    busy_o     = state inside {PASS_RST, PASS_RUN, PASS_CLR, SWAP};
    case (state)
      PASS_RST, PASS_CLR: pass_rst_o = k_sel;
      PASS_RUN:           pass_en_o  = vsync_i ? '0 : k_sel;
      SWAP:               seq_done_o = 1'b1;
      default: ;
    endcase
    // show the front bank only, never the one the final pass is writing
    if (state != IDLE_LIVE && result_valid) disp_sel_o = wr_bank ? 2'b01 : 2'b10;
  end

  assign active_pass_o = k;
  assign wr_bank_o     = wr_bank;
  assign timeout_o     = timeout;
  assign frame_cnt_o   = frame_cnt;

endmodule
